// File: rtl/mux_scan_pkg.sv
// Shared types and default widths for the channel scanner and the 8:1 data mux.
package mux_scan_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int NUM_CH_DEF  = 8;
  localparam int SEL_W_DEF   = 3;
  localparam int DWELL_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HOLD  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/mux_scan_next.sv
// Rotate-priority encoder: next enabled channel above the current one, the
// lowest enabled channel, and whether the search had to wrap to find it.
module mux_scan_next
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              wrap_o,
  output logic [SEL_W-1:0]  first_o
);

  logic found;

  always_comb begin
    first_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) first_o = SEL_W'(i);
    end

    // No enabled channel above cur_i means the pass is complete.
    next_o = first_o;
    found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && mask_i[i] && (SEL_W'(i) > cur_i)) begin
        next_o = SEL_W'(i);
        found  = 1'b1;
      end
    end
    wrap_o = !found;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel scanner: steps the mux select over a masked channel set, dwells on
// each channel, then hands the sample to the consumer over valid/ready.
//   state | meaning
//   IDLE  | waiting for start with a nonzero mask
//   DWELL | mux settling, counter running down
//   HOLD  | result presented, waiting for res_ready
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   mux_sel,
  input  logic [DATA_W-1:0]  mux_out,
  output logic [DATA_W-1:0]  res_data,
  output logic [SEL_W-1:0]   res_ch,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               scan_done
);

  scan_state_e        state_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [NUM_CH-1:0]  mask_q;
  logic               cont_q;
  logic [SEL_W-1:0]   sel_q;
  logic [DATA_W-1:0]  data_q;
  logic [SEL_W-1:0]   ch_q;
  logic               valid_q;
  logic               done_q;

  logic [DWELL_W-1:0] dwell_d;
  logic [NUM_CH-1:0]  mask_d;
  logic [SEL_W-1:0]   next_ch;
  logic [SEL_W-1:0]   first_ch;
  logic               wrap;

  assign dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
  // In IDLE the live mask picks the first channel; afterwards the latched one.
  assign mask_d  = (state_q == ST_IDLE) ? ch_mask : mask_q;

  mux_scan_next #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_next (
    .mask_i  (mask_d),
    .cur_i   (sel_q),
    .next_o  (next_ch),
    .wrap_o  (wrap),
    .first_o (first_ch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && (ch_mask != '0)) begin
            mask_q  <= ch_mask;
            cont_q  <= cont;
            dwell_q <= dwell_d;
            cnt_q   <= dwell_d;
            sel_q   <= first_ch;
            state_q <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          cnt_q <= cnt_q - DWELL_W'(1);
          if (cnt_q == DWELL_W'(1)) begin
            data_q  <= mux_out;
            ch_q    <= sel_q;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            if (wrap) begin
              done_q <= 1'b1;
              if (cont_q && !stop) begin
                sel_q   <= first_ch;
                cnt_q   <= dwell_q;
                state_q <= ST_DWELL;
              end else begin
                state_q <= ST_IDLE;
              end
            end else if (stop) begin
              state_q <= ST_IDLE;
            end else begin
              sel_q   <= next_ch;
              cnt_q   <= dwell_q;
              state_q <= ST_DWELL;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mux_sel   = sel_q;
  assign res_data  = data_q;
  assign res_ch    = ch_q;
  assign res_valid = valid_q;
  assign scan_done = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: an 8-lane combinational mux model feeds the
// scanner and each step checks outputs 1 time unit after the rising edge.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] ch_mask;
  logic [3:0] dwell;
  logic [2:0] mux_sel;
  logic [3:0] mux_out;
  logic [3:0] res_data;
  logic [2:0] res_ch;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       scan_done;

  logic [3:0] lanes [8];

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign mux_out = lanes[mux_sel];

  mux_scan_ctrl #(
    .DATA_W  (4),
    .NUM_CH  (8),
    .SEL_W   (3),
    .DWELL_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .mux_sel   (mux_sel),
    .mux_out   (mux_out),
    .res_data  (res_data),
    .res_ch    (res_ch),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .scan_done (scan_done)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},   {5'd0, mux_sel}, 8'h00);
    chk({tag, "_data"},  {4'd0, res_data}, 8'h00);
    chk({tag, "_ch"},    {5'd0, res_ch}, 8'h00);
    chk({tag, "_valid"}, {7'd0, res_valid}, 8'h00);
    chk({tag, "_busy"},  {7'd0, busy}, 8'h00);
    chk({tag, "_done"},  {7'd0, scan_done}, 8'h00);
  endtask

  // Called just after the edge that started DWELL on channel ch (res_ready = 1).
  task automatic check_result(input string tag, input logic [2:0] ch, input logic [3:0] data,
                              input int d, input logic exp_done, input logic exp_busy);
    tick(d - 1);
    chk({tag, "_early_valid"}, {7'd0, res_valid}, 8'h00);
    tick(1);
    chk({tag, "_valid"}, {7'd0, res_valid}, 8'h01);
    chk({tag, "_ch"},    {5'd0, res_ch}, {5'd0, ch});
    chk({tag, "_data"},  {4'd0, res_data}, {4'd0, data});
    tick(1);
    chk({tag, "_done"},     {7'd0, scan_done}, {7'd0, exp_done});
    chk({tag, "_busy"},     {7'd0, busy}, {7'd0, exp_busy});
    chk({tag, "_valid_lo"}, {7'd0, res_valid}, 8'h00);
  endtask

  initial begin
    lanes[0] = 4'ha; lanes[1] = 4'hb; lanes[2] = 4'hc; lanes[3] = 4'hd;
    lanes[4] = 4'he; lanes[5] = 4'hf; lanes[6] = 4'h8; lanes[7] = 4'h7;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    ch_mask = 8'h00; dwell = 4'd1; res_ready = 1'b1;

    tick(2);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick(1);

    // Full scan, dwell 1, no backpressure
    ch_mask = 8'hff; dwell = 4'd1; cont = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("full_busy", {7'd0, busy}, 8'h01);
    chk("full_sel0", {5'd0, mux_sel}, 8'h00);
    check_result("full0", 3'd0, 4'ha, 1, 1'b0, 1'b1);
    check_result("full1", 3'd1, 4'hb, 1, 1'b0, 1'b1);
    check_result("full2", 3'd2, 4'hc, 1, 1'b0, 1'b1);
    check_result("full3", 3'd3, 4'hd, 1, 1'b0, 1'b1);
    check_result("full4", 3'd4, 4'he, 1, 1'b0, 1'b1);
    check_result("full5", 3'd5, 4'hf, 1, 1'b0, 1'b1);
    check_result("full6", 3'd6, 4'h8, 1, 1'b0, 1'b1);
    check_result("full7", 3'd7, 4'h7, 1, 1'b1, 1'b0);

    // Sparse mask, dwell 3
    ch_mask = 8'b1010_0100; dwell = 4'd3; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("sparse_sel", {5'd0, mux_sel}, 8'h02);
    check_result("sparse2", 3'd2, 4'hc, 3, 1'b0, 1'b1);
    chk("sparse_sel5", {5'd0, mux_sel}, 8'h05);
    check_result("sparse5", 3'd5, 4'hf, 3, 1'b0, 1'b1);
    check_result("sparse7", 3'd7, 4'h7, 3, 1'b1, 1'b0);

    // Dwell 0 behaves as dwell 1
    ch_mask = 8'h06; dwell = 4'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    check_result("dw0_1", 3'd1, 4'hb, 1, 1'b0, 1'b1);
    check_result("dw0_2", 3'd2, 4'hc, 1, 1'b1, 1'b0);

    // Empty mask start is ignored
    ch_mask = 8'h00; dwell = 4'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("empty_busy",  {7'd0, busy}, 8'h00);
    chk("empty_done",  {7'd0, scan_done}, 8'h00);
    chk("empty_valid", {7'd0, res_valid}, 8'h00);
    tick(3);
    chk("empty_busy2",  {7'd0, busy}, 8'h00);
    chk("empty_valid2", {7'd0, res_valid}, 8'h00);

    // Backpressure, plus a start and input changes while busy
    ch_mask = 8'h10; dwell = 4'd2; res_ready = 1'b0; start = 1'b1;
    tick(1);
    ch_mask = 8'h01; dwell = 4'd9; cont = 1'b1;
    tick(1);
    start = 1'b0;
    chk("bp_sel", {5'd0, mux_sel}, 8'h04);
    tick(1);
    chk("bp_valid", {7'd0, res_valid}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {7'd0, res_valid}, 8'h01);
      chk("bp_hold_ch",    {5'd0, res_ch}, 8'h04);
      chk("bp_hold_data",  {4'd0, res_data}, 8'h0e);
      chk("bp_hold_sel",   {5'd0, mux_sel}, 8'h04);
      tick(1);
    end
    res_ready = 1'b1;
    tick(1);
    chk("bp_done",  {7'd0, scan_done}, 8'h01);
    chk("bp_busy",  {7'd0, busy}, 8'h00);
    chk("bp_valid_lo", {7'd0, res_valid}, 8'h00);
    tick(2);
    chk("bp_idle", {7'd0, busy}, 8'h00);

    // Continuous mode, mask 0x81
    ch_mask = 8'h81; dwell = 4'd1; cont = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    check_result("cont0a", 3'd0, 4'ha, 1, 1'b0, 1'b1);
    check_result("cont7a", 3'd7, 4'h7, 1, 1'b1, 1'b1);
    chk("cont_wrap_sel", {5'd0, mux_sel}, 8'h00);
    check_result("cont0b", 3'd0, 4'ha, 1, 1'b0, 1'b1);
    check_result("cont7b", 3'd7, 4'h7, 1, 1'b1, 1'b1);

    // Stop during ch0 HOLD: idle after handshake, no pulse
    tick(1);
    chk("stop_valid", {7'd0, res_valid}, 8'h01);
    chk("stop_ch",    {5'd0, res_ch}, 8'h00);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_done",  {7'd0, scan_done}, 8'h00);
    chk("stop_busy",  {7'd0, busy}, 8'h00);
    chk("stop_valid_lo", {7'd0, res_valid}, 8'h00);

    // Reset while in HOLD with a result pending
    start = 1'b1;
    tick(1);
    start = 1'b0;
    res_ready = 1'b0;
    tick(1);
    chk("rsthold_valid", {7'd0, res_valid}, 8'h01);
    chk("rsthold_data",  {4'd0, res_data}, 8'h0a);
    rst = 1'b1;
    tick(1);
    chk_reset_vals("rsthold");
    rst = 1'b0;
    res_ready = 1'b1;
    tick(2);
    chk("post_rst_busy", {7'd0, busy}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Channel scanner that sits directly upstream of the 8:1 4-bit data mux. It drives the mux select and captures the mux output. It steps through a masked set of channels, holding each channel for a programmable dwell time. It then presents each sampled value, tagged with its channel number, to a downstream consumer over a valid/ready handshake.

## Interface
- `DATA_W`, default 4: width of each mux data lane and of the captured result.
- `NUM_CH`, default 8: number of mux channels.
- `SEL_W`, default 3: select width, equal to clog2(`NUM_CH`).
- `DWELL_W`, default 4: width of the dwell-count input.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- `stop`  in  1  level; ends a continuous scan at the next channel advance.
- `cont`  in  1  1 = continuous scan (wrap forever); 0 = single pass. Latched at start.
- `ch_mask`  in  `NUM_CH`  enabled channels, bit i = channel i. Latched at start.
- `dwell`  in  `DWELL_W`  settle cycles per channel; 0 is treated as 1. Latched at start.
- `mux_sel`  out  `SEL_W`  select driven to the mux, registered.
- `mux_out`  in  `DATA_W`  data returned by the mux.
- `res_data`  out  `DATA_W`  captured sample.
- `res_ch`  out  `SEL_W`  channel that `res_data` came from.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.
- `scan_done`  out  1  one-cycle pulse when a pass completes.

## Operation
- The FSM has three states: IDLE, DWELL and HOLD.
- IDLE → DWELL: on `start` with a nonzero `ch_mask`. On the same edge:
  - latch mask, dwell and cont;
  - load `mux_sel` with the lowest set mask bit;
  - load the dwell counter with max(`dwell`, 1).
- `start` with `ch_mask` == 0 is ignored: the block stays in IDLE, `busy` stays 0, and no pulse is produced.
- DWELL: decrement the counter every cycle. When the counter is 1, on that edge:
  - `res_data` ← `mux_out`, `res_ch` ← `mux_sel`, `res_valid` ← 1;
  - go to HOLD.
- HOLD: `res_valid`, `res_data`, `res_ch` and `mux_sel` are all held stable until `res_valid && res_ready`. On that handshake edge:
  - `res_valid` ← 0;
  - next channel = the next set mask bit strictly above `mux_sel`, with wrap-around.
- Wrap rule: if the search wraps, or the current channel is the highest enabled one, the pass is complete.
  - `scan_done` pulses on that same edge.
  - If `cont` = 1 and `stop` = 0: load the lowest enabled channel and go to DWELL.
  - Otherwise go to IDLE.
- If the pass is not complete:
  - `stop` = 1 → go to IDLE, with no `scan_done` pulse;
  - otherwise load the next channel, reload the dwell counter, and go to DWELL.
- `start` while busy is ignored.
- Changes to `ch_mask`, `dwell` or `cont` while busy have no effect until the next start.
- A single enabled channel with `cont` = 1 resamples that channel every pass, and `scan_done` pulses on every handshake.

## Timing
- Reset values:
  - `mux_sel`=0, `res_data`=0, `res_ch`=0;
  - `res_valid`=0, `busy`=0, `scan_done`=0;
  - state = IDLE, counter = 0.
- Reset at any point, including HOLD with `res_valid` high, aborts the scan. All outputs take their reset values on that edge.
- Latency: `start` sampled at edge k → `mux_sel` valid after edge k; `res_valid` high after edge k+D, where D = max(`dwell`, 1).
- Throughput with `res_ready` held at 1: one result every D+1 cycles (D dwell cycles plus 1 HOLD cycle).
- `mux_out` is treated as combinational from `mux_sel`. The dwell time covers mux settling; no extra pipeline stage.
- `busy` falls on the same edge the FSM enters IDLE.
- `scan_done` and the final handshake occur on the same edge.

## Structure
- Shared package `mux_scan_pkg` holds:
  - the state enum (IDLE, DWELL, HOLD);
  - default `DATA_W`, `NUM_CH` and `SEL_W` constants, shared with the mux.
- One natural sub-module, `mux_scan_next`: combinational rotate-priority encoder.
  - Inputs: mask and current index.
  - Outputs: next index, wrap flag, first-set index.

## Test plan
- Reset check: assert `rst` for 2 cycles → all outputs 0, `busy`=0, `mux_sel`=0.
- Full scan, no backpressure:
  - stimulus: mux data = a,b,c,d,e,f,8,7; `ch_mask`=8'hFF; `dwell`=1; `cont`=0; `res_ready`=1;
  - expect results (ch,data) = (0,a),(1,b)…(7,7), one every 2 cycles;
  - expect `scan_done` on the ch7 handshake, then `busy`=0.
- Sparse mask with dwell:
  - stimulus: `ch_mask`=8'b1010_0100, `dwell`=3;
  - expect results (2,c),(5,f),(7,7), spaced 4 cycles apart; first `res_valid` 3 cycles after `start`.
- Backpressure: hold `res_ready`=0 for 5 cycles in HOLD → `res_valid`, `res_data`, `res_ch` and `mux_sel` stay constant; the result is accepted on the first ready cycle.
- Corner inputs:
  - `start` with `ch_mask`=0 → no activity;
  - `dwell`=0 → identical timing to `dwell`=1;
  - `start` pulsed while busy → ignored.
- Continuous mode:
  - `cont`=1, mask 8'h81 → 0,7,0,7…, with `scan_done` on each ch7 handshake;
  - `stop` raised during ch0 HOLD → IDLE after the ch0 handshake, no pulse;
  - `rst` during HOLD → immediate reset values.
